pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It owns the write-enable and flush controls of the F/D/E/M/W pipeline registers and tracks the multi-cycle multiply/divide unit with a busy counter. It merges three stall sources into one set of register controls: data hazards, HI/LO busy and exception/interrupt requests. The controls are `we`, the per-stage bubble flush, and `req` for the 0x0000_4180 redirect.

## Interface
Parameters:
- `MUL_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.

Ports (one clock, `clk`; reset is `reset`, asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `reset` input 1: async active-high; forces all state and outputs to reset values.
- `data_stall` input 1: load-use / RAW hazard from the forwarding unit (combinational).
- `d_uses_md` input 1: instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- `e_md_start` input 1: instruction in E is mult/multu/div/divu (start request).
- `e_md_is_div` input 1: qualifies `e_md_start`; 1 = divide.
- `int_req` input 1: exception/interrupt taken at M (from CP0).
- `f_we` output 1: PC / F-register write enable.
- `d_we` output 1: D-register write enable.
- `e_flush` output 1: clear E register (bubble).
- `req` output 1: broadcast to all pipeline registers; they load zero and PC loads 0x0000_4180.
- `md_start` output 1: qualified start to the MD datapath.
- `md_busy` output 1: MD unit busy (registered).
- `md_done` output 1: one-cycle pulse on the last busy cycle (registered).
- `proto_err` output 1: sticky; set on an illegal start.

## Operation
- FSM states: IDLE, MUL, DIV. Down-counter `cnt`, 4 bits, enough for `DIV_CYCLES` ≤ 15.
- `md_start = e_md_start & ~int_req & (state==IDLE)`.
- IDLE with `md_start`:
  - go to MUL if `e_md_is_div`=0, loading `cnt = MUL_CYCLES-1`.
  - go to DIV if `e_md_is_div`=1, loading `cnt = DIV_CYCLES-1`.
- MUL/DIV: decrement each cycle. When `cnt==0`, return to IDLE.
- `md_busy = (state!=IDLE)`. `md_done = busy & cnt==0`.
- `int_req` never aborts a running operation. That operation belongs to an older instruction that is already committed. A start requested in the same cycle as `int_req` is suppressed, because that instruction is younger.
- `e_md_start` while state≠IDLE is illegal: the start is ignored and `proto_err` is set. Only `reset` clears `proto_err`.
- Hazard: `hz = data_stall | (d_uses_md & (md_busy | md_start))`.
- Output priority:
  1. `int_req`=1: `req`=1, `f_we`=1, `d_we`=1, `e_flush`=0; `hz` is ignored.
  2. `hz`=1: `f_we`=0, `d_we`=0, `e_flush`=1.
  3. Otherwise: `f_we`=1, `d_we`=1, `e_flush`=0, `req`=0.
- `req`, `f_we`, `d_we`, `e_flush` and `md_start` are combinational from inputs and registered state. `md_busy`, `md_done` and `proto_err` are purely registered.

## Timing
- Reset values: state=IDLE, `cnt`=0, `md_busy`=0, `md_done`=0, `proto_err`=0. Combinational outputs follow with inputs idle: `f_we`=1, `d_we`=1, `e_flush`=0, `req`=0, `md_start`=0.
- Start accepted at edge t: `md_busy` is high for cycles t+1 … t+N (N = MUL_CYCLES or DIV_CYCLES). `md_done` is high in cycle t+N.
- A dependent instruction in D stalls from the start cycle through cycle t+N. It advances on the edge ending cycle t+N.
- Back-to-back: a start in cycle t+N+1 is legal.
- Reset asserted mid-operation: busy drops asynchronously with no `md_done`.
- `int_req` in the cycle of `md_done`: done still pulses; `req` still asserts.

## Structure
- Shared package/header (`const.v`):
  - `EXC_ENTRY` = 32'h0000_4180.
  - state encodings `MDS_IDLE`, `MDS_MUL`, `MDS_DIV`.
  - default `MUL_CYCLES` / `DIV_CYCLES`.
- One natural sub-module, `md_busy_cnt`: the FSM plus counter, producing `md_busy` / `md_done` / `proto_err`. The top level holds only the priority logic.

## Test plan
- Reset idle → `f_we`=1, `d_we`=1, `e_flush`=0, `req`=0, `md_busy`=0.
- `e_md_start`=1, `e_md_is_div`=0, then `d_uses_md`=1 held → `md_busy` high exactly 5 cycles, `md_done` on the 5th. D stalls 6 cycles including the start cycle, then `d_we`=1.
- Div start, `int_req` pulsed on cycle 3 of busy → `req`=1 that cycle and busy continues to 10 cycles total. Start in the same cycle as `int_req` → `md_start`=0, state stays IDLE.
- `e_md_start` while busy → ignored, busy length unchanged, `proto_err`=1 until reset.
- `data_stall`=1 and `int_req`=1 together → `req`=1, `f_we`=1, `e_flush`=0.
- `reset` asserted asynchronously mid-divide (between clock edges) → `md_busy`=0 immediately, no `md_done`, `proto_err`=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and state encodings for the pipeline sequencing controller.
package pipe_stall_ctrl_pkg;

  localparam logic [31:0] EXC_ENTRY      = 32'h0000_4180;
  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the core and the controller.
interface pipe_stall_ctrl_if;

  logic data_stall;
  logic d_uses_md;
  logic e_md_start;
  logic e_md_is_div;
  logic int_req;

  logic f_we;
  logic d_we;
  logic e_flush;
  logic req;
  logic md_start;
  logic md_busy;
  logic md_done;
  logic proto_err;

  modport master (
    output data_stall, d_uses_md, e_md_start, e_md_is_div, int_req,
    input  f_we, d_we, e_flush, req, md_start, md_busy, md_done, proto_err
  );

  modport slave (
    input  data_stall, d_uses_md, e_md_start, e_md_is_div, int_req,
    output f_we, d_we, e_flush, req, md_start, md_busy, md_done, proto_err
  );

endinterface

// File: rtl/pipe_stall_ctrl_md_busy_cnt.sv
// Multiply/divide occupancy tracker: IDLE/MUL/DIV FSM with a down-counter.
// Busy, done and the sticky protocol error are all decoded from registers only.
module pipe_stall_ctrl_md_busy_cnt
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_e_md_start,
  input  logic i_is_div,
  output logic o_idle,
  output logic o_busy,
  output logic o_done,
  output logic o_proto_err
);

  md_state_e        r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_proto_err, w_proto_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= MDS_IDLE;
      r_cnt       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_proto_err <= w_proto_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    // A start request while an operation is in flight is dropped but remembered.
    w_proto_err_d = r_proto_err | (i_e_md_start & (r_state != MDS_IDLE));
    unique case (r_state)
      MDS_IDLE: begin
        if (i_start) begin
          w_state_d = i_is_div ? MDS_DIV : MDS_MUL;
          w_cnt_d   = i_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end
      end
      MDS_MUL, MDS_DIV: begin
        if (r_cnt == '0) begin
          w_state_d = MDS_IDLE;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_d = MDS_IDLE;
    endcase
  end

  assign o_idle      = (r_state == MDS_IDLE);
  assign o_busy      = (r_state != MDS_IDLE);
  assign o_done      = o_busy & (r_cnt == '0);
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges data hazards, HI/LO busy and exception requests
// into F/D write enables, the E bubble flush and the exception redirect.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave bus
);

  logic w_idle;
  logic w_busy;
  logic w_done;
  logic w_proto_err;
  logic w_md_start;
  logic w_hz;
  logic w_f_we;
  logic w_d_we;
  logic w_e_flush;
  logic w_req;

  // The start belongs to a younger instruction than the one trapping at M, so it is squashed.
  assign w_md_start = bus.e_md_start & ~bus.int_req & w_idle;
  assign w_hz       = bus.data_stall | (bus.d_uses_md & (w_busy | w_md_start));

  pipe_stall_ctrl_md_busy_cnt #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_md_start),
    .i_e_md_start (bus.e_md_start),
    .i_is_div     (bus.e_md_is_div),
    .o_idle       (w_idle),
    .o_busy       (w_busy),
    .o_done       (w_done),
    .o_proto_err  (w_proto_err)
  );

  always_comb begin
    w_f_we    = 1'b1;
    w_d_we    = 1'b1;
    w_e_flush = 1'b0;
    w_req     = 1'b0;
    if (bus.int_req) begin
      w_req = 1'b1;
    end else if (w_hz) begin
      w_f_we    = 1'b0;
      w_d_we    = 1'b0;
      w_e_flush = 1'b1;
    end
  end

  assign bus.f_we      = w_f_we;
  assign bus.d_we      = w_d_we;
  assign bus.e_flush   = w_e_flush;
  assign bus.req       = w_req;
  assign bus.md_start  = w_md_start;
  assign bus.md_busy   = w_busy;
  assign bus.md_done   = w_done;
  assign bus.proto_err = w_proto_err;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: stateless vector table, then multi-cycle MD sequences
// checked through an expected-output queue sampled on the falling edge.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic data_stall;
    logic d_uses_md;
    logic e_md_start;
    logic e_md_is_div;
    logic int_req;
  } in_t;

  // {f_we, d_we, e_flush, req, md_start, md_busy, md_done, proto_err}
  typedef logic [7:0] out_t;

  typedef struct {
    in_t   in;
    out_t  exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  out_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic in_t mk(input logic ds, input logic du, input logic st, input logic dv,
                             input logic ir);
    in_t v;
    v.data_stall  = ds;
    v.d_uses_md   = du;
    v.e_md_start  = st;
    v.e_md_is_div = dv;
    v.int_req     = ir;
    return v;
  endfunction

  function automatic out_t sample();
    return {bus.f_we, bus.d_we, bus.e_flush, bus.req,
            bus.md_start, bus.md_busy, bus.md_done, bus.proto_err};
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (f_we d_we e_flush req md_start busy done perr)",
               name, got, exp);
    end
  endtask

  task automatic drive(input in_t in);
    bus.data_stall  = in.data_stall;
    bus.d_uses_md   = in.d_uses_md;
    bus.e_md_start  = in.e_md_start;
    bus.e_md_is_div = in.e_md_is_div;
    bus.int_req     = in.int_req;
  endtask

  // Scoreboard side: every queued expectation is compared against the settled outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check(name_q.pop_front(), sample(), exp_q.pop_front());
  end

  task automatic step(input in_t in, input out_t exp, input string name);
    @(posedge clk);
    #1;
    drive(in);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    #1;
  endtask

  localparam out_t O_IDLE  = 8'b1100_0000;
  localparam out_t O_STALL = 8'b0010_0000;
  localparam out_t O_REQ   = 8'b1101_0000;

  initial begin
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0));
    #12;
    check("reset_state", sample(), O_IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;

    vecs.push_back('{mk(0, 0, 0, 0, 0), O_IDLE,  "idle"});
    vecs.push_back('{mk(1, 0, 0, 0, 0), O_STALL, "raw_stall"});
    vecs.push_back('{mk(0, 1, 0, 0, 0), O_IDLE,  "md_use_idle"});
    vecs.push_back('{mk(0, 0, 0, 0, 1), O_REQ,   "int_only"});
    vecs.push_back('{mk(1, 0, 0, 0, 1), O_REQ,   "stall_and_int"});
    vecs.push_back('{mk(0, 0, 1, 0, 1), O_REQ,   "start_mul_with_int"});
    vecs.push_back('{mk(0, 1, 1, 1, 1), O_REQ,   "start_div_with_int"});
    vecs.push_back('{mk(1, 1, 0, 0, 0), O_STALL, "raw_and_md_use"});
    vecs.push_back('{mk(0, 0, 0, 0, 0), O_IDLE,  "still_idle"});
    foreach (vecs[i]) step(vecs[i].in, vecs[i].exp, vecs[i].name);

    // Multiply with a dependent instruction held in D: 6 stall cycles, then it advances.
    step(mk(0, 1, 1, 0, 0), 8'b0010_1000, "mul_start_stall");
    for (int i = 1; i <= 5; i++)
      step(mk(0, 1, 0, 0, 0), (i == 5) ? 8'b0010_0110 : 8'b0010_0100, "mul_busy_stall");
    step(mk(0, 1, 0, 0, 0), O_IDLE, "mul_dep_released");

    // Divide with an interrupt on busy cycle 3: redirect fires, divide runs its full 10 cycles.
    step(mk(0, 0, 1, 1, 0), 8'b1100_1000, "div_start");
    for (int i = 1; i <= 10; i++)
      step(mk(0, 0, 0, 0, (i == 3)),
           (i == 3) ? 8'b1101_0100 : (i == 10) ? 8'b1100_0110 : 8'b1100_0100, "div_busy");
    step(mk(0, 0, 0, 0, 0), O_IDLE, "div_finished");

    // Illegal restart while busy, then a legal back-to-back start with int_req on done.
    step(mk(0, 0, 1, 0, 0), 8'b1100_1000, "mul2_start");
    step(mk(0, 0, 0, 0, 0), 8'b1100_0100, "mul2_busy1");
    step(mk(0, 0, 1, 1, 0), 8'b1100_0100, "illegal_start");
    for (int i = 3; i <= 5; i++)
      step(mk(0, 0, 0, 0, 0), (i == 5) ? 8'b1100_0111 : 8'b1100_0101, "mul2_len_unchanged");
    step(mk(0, 0, 1, 0, 0), 8'b1100_1001, "back_to_back_start");
    for (int i = 1; i <= 5; i++)
      step(mk(0, 0, 0, 0, (i == 5)), (i == 5) ? 8'b1101_0111 : 8'b1100_0101, "mul3_busy");
    step(mk(0, 0, 0, 0, 0), 8'b1100_0001, "perr_sticky");

    // Asynchronous reset in the middle of a divide.
    step(mk(0, 0, 1, 1, 0), 8'b1100_1001, "div2_start");
    for (int i = 1; i <= 4; i++)
      step(mk(0, 0, 0, 0, 0), 8'b1100_0101, "div2_busy");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_mid_div", sample(), O_IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(mk(0, 0, 0, 0, 0), O_IDLE, "after_reset_1");
    step(mk(0, 0, 0, 0, 0), O_IDLE, "after_reset_2");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
